// File: rtl/melody_sequencer_pkg.sv
// rtl/melody_sequencer_pkg.sv - shared types, field positions and default song for the melody sequencer
package melody_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SCALE = 3'd2,
        S_NOTE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    // Song entry layout: {octave[1:0], note[2:0], dur[2:0]}
    localparam int OCT_MSB  = 7;
    localparam int OCT_LSB  = 6;
    localparam int NOTE_MSB = 5;
    localparam int NOTE_LSB = 3;
    localparam int DUR_MSB  = 2;
    localparam int DUR_LSB  = 0;

    localparam logic [1:0] OCT_END    = 2'd3;
    localparam logic [3:0] SCALE_BASE = 4'hA;

    // Wide enough for 8 duration units at the default tick length
    localparam int CNT_W = 26;

    // Default song: mid-octave C-major up, high C held, back down, then end marker
    function automatic logic [7:0] song_entry(input int unsigned i);
        if (i < 7)
            return {2'd1, 3'(i + 1), 3'd1};
        else if (i == 7)
            return {2'd2, 3'd1, 3'd3};
        else if (i < 15)
            return {2'd1, 3'(15 - i), 3'd1};
        else
            return {OCT_END, 3'd0, 3'd0};
    endfunction

endpackage

// File: rtl/melody_rom.sv
// rtl/melody_rom.sv - song ROM with one-cycle synchronous read
module melody_rom
    import melody_sequencer_pkg::*;
#(
    parameter int unsigned               SONG_LEN   = 32,
    parameter bit                        CUSTOM_ROM = 1'b0,
    parameter logic [8*SONG_LEN-1:0]     ROM_INIT   = '0
) (
    input  logic                          clk,
    input  logic [$clog2(SONG_LEN)-1:0]   addr,
    output logic [7:0]                    data
);

    // Registered read; a custom image (entry 0 in the low byte) replaces the built-in song
    always_ff @(posedge clk) begin
        if (CUSTOM_ROM)
            data <= ROM_INIT[{addr, 3'b000} +: 8];
        else
            data <= song_entry(32'(addr));
    end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - autoplay engine and keypad arbiter driving the tone generator
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int unsigned               TICK_CYC   = 6_250_000,
    parameter int unsigned               GAP_CYC    = 1_000_000,
    parameter int unsigned               SONG_LEN   = 32,
    parameter bit                        CUSTOM_ROM = 1'b0,
    parameter logic [8*SONG_LEN-1:0]     ROM_INIT   = '0
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          pause,
    input  logic                          loop_en,
    input  logic                          man_pressed,
    input  logic [3:0]                    man_data,
    output logic                          kb_pressed,
    output logic [3:0]                    kb_data,
    output logic                          busy,
    output logic [$clog2(SONG_LEN)-1:0]   note_idx,
    output logic                          done
);

    localparam int IDX_W = $clog2(SONG_LEN);
    localparam logic [CNT_W-1:0] TICK_LEN = CNT_W'(TICK_CYC);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SONG_LEN - 1);

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [3:0]         kb_data_n;
    logic               kb_pressed_n;
    logic               done_n;
    logic               end_song;

    logic [7:0]         entry;
    logic [1:0]         oct;
    logic [2:0]         note;
    logic [2:0]         dur;
    logic [CNT_W-1:0]   note_last;
    logic               override;

    // ROM is addressed with the next index so the entry is already valid during LOAD
    melody_rom #(
        .SONG_LEN   (SONG_LEN),
        .CUSTOM_ROM (CUSTOM_ROM),
        .ROM_INIT   (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (idx_n),
        .data (entry)
    );

    assign oct       = entry[OCT_MSB:OCT_LSB];
    assign note      = entry[NOTE_MSB:NOTE_LSB];
    assign dur       = entry[DUR_MSB:DUR_LSB];
    assign note_last = (CNT_W'(dur) + CNT_W'(1)) * TICK_LEN - CNT_W'(1);

    // A live note key (1-7) takes the generator away from the autoplay engine
    assign override  = man_pressed && (man_data != 4'd0) && !man_data[3];

    assign busy      = (state != S_IDLE);
    assign note_idx  = idx;

    // State, index, counter and registered generator outputs
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            kb_data    <= 4'h0;
            kb_pressed <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            kb_data    <= kb_data_n;
            kb_pressed <= kb_pressed_n;
            done       <= done_n;
        end
    end

    // Next state plus the generator outputs that take effect with it
    always_comb begin
        state_n      = state;
        idx_n        = idx;
        cnt_n        = cnt;
        kb_data_n    = kb_data;
        kb_pressed_n = kb_pressed;
        done_n       = 1'b0;
        end_song     = 1'b0;

        if (state == S_IDLE) begin
            kb_data_n    = man_data;
            kb_pressed_n = man_pressed;
            if (start && !stop) begin
                state_n      = S_LOAD;
                idx_n        = '0;
                cnt_n        = '0;
                kb_data_n    = 4'h0;
                kb_pressed_n = 1'b0;
            end
        end else if (stop) begin
            state_n      = S_IDLE;
            cnt_n        = '0;
            kb_data_n    = 4'h0;
            kb_pressed_n = 1'b0;
        end else if (override) begin
            state_n      = S_IDLE;
            cnt_n        = '0;
            kb_data_n    = man_data;
            kb_pressed_n = man_pressed;
        end else begin
            case (state)
                S_LOAD: begin
                    kb_data_n    = 4'h0;
                    kb_pressed_n = 1'b0;
                    if (oct == OCT_END) begin
                        end_song = 1'b1;
                    end else begin
                        state_n   = S_SCALE;
                        kb_data_n = SCALE_BASE + {2'b00, oct};
                    end
                end
                S_SCALE: begin
                    state_n      = S_NOTE;
                    cnt_n        = '0;
                    kb_data_n    = {1'b0, note};
                    kb_pressed_n = 1'b1;
                end
                S_NOTE: begin
                    if (pause) begin
                        kb_pressed_n = 1'b0;
                    end else if (cnt == note_last) begin
                        state_n      = S_GAP;
                        cnt_n        = '0;
                        kb_data_n    = 4'h0;
                        kb_pressed_n = 1'b0;
                    end else begin
                        cnt_n        = cnt + CNT_W'(1);
                        kb_pressed_n = 1'b1;
                    end
                end
                S_GAP: begin
                    kb_data_n    = 4'h0;
                    kb_pressed_n = 1'b0;
                    if (!pause) begin
                        if (cnt == GAP_LAST) begin
                            cnt_n = '0;
                            idx_n = idx + IDX_W'(1);
                            if (idx == IDX_LAST)
                                end_song = 1'b1;
                            else
                                state_n = S_LOAD;
                        end else begin
                            cnt_n = cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n      = S_IDLE;
                    kb_data_n    = 4'h0;
                    kb_pressed_n = 1'b0;
                end
            endcase

            if (end_song) begin
                cnt_n        = '0;
                kb_data_n    = 4'h0;
                kb_pressed_n = 1'b0;
                if (loop_en) begin
                    idx_n   = '0;
                    state_n = S_LOAD;
                end else begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb/tb_melody_sequencer.sv - self-checking bench for melody_sequencer with a short test song
module tb_melody_sequencer;

    localparam int TICK = 4;
    localparam int GAPC = 2;
    localparam int LEN  = 4;

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       loop_en = 1'b0;
    logic       man_pressed = 1'b0;
    logic [3:0] man_data = 4'h0;
    logic       kb_pressed;
    logic [3:0] kb_data;
    logic       busy;
    logic [1:0] note_idx;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] data;
        logic       pressed;
        logic       busy;
        logic [1:0] idx;
        logic       done;
        byte        ph;
    } item_t;

    item_t      exp_q[$];
    logic [7:0] rom_tab [LEN];

    melody_sequencer #(
        .TICK_CYC   (TICK),
        .GAP_CYC    (GAPC),
        .SONG_LEN   (LEN),
        .CUSTOM_ROM (1'b1),
        .ROM_INIT   (32'hFF00_A948)
    ) dut (
        .clk         (clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .loop_en     (loop_en),
        .man_pressed (man_pressed),
        .man_data    (man_data),
        .kb_pressed  (kb_pressed),
        .kb_data     (kb_data),
        .busy        (busy),
        .note_idx    (note_idx),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic item_t mk(input logic [3:0] d, input logic p, input logic b,
                                 input logic [1:0] i, input logic dn, input byte ph);
        item_t t;
        t.data    = d;
        t.pressed = p;
        t.busy    = b;
        t.idx     = i;
        t.done    = dn;
        t.ph      = ph;
        return t;
    endfunction

    // Expected per-cycle output trace of whole passes through the song, without pauses
    task automatic build(input int passes, input bit lp);
        logic [7:0] e;
        exp_q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int i = 0; i < LEN; i++) begin
                e = rom_tab[i];
                exp_q.push_back(mk(4'h0, 1'b0, 1'b1, 2'(i), 1'b0, "L"));
                if (e[7:6] == 2'd3) begin
                    if (!lp) exp_q.push_back(mk(4'h0, 1'b0, 1'b0, 2'(i), 1'b1, "E"));
                    break;
                end
                exp_q.push_back(mk(4'hA + {2'b00, e[7:6]}, 1'b0, 1'b1, 2'(i), 1'b0, "S"));
                for (int c = 0; c < (int'(e[2:0]) + 1) * TICK; c++)
                    exp_q.push_back(mk({1'b0, e[5:3]}, 1'b1, 1'b1, 2'(i), 1'b0, "N"));
                for (int c = 0; c < GAPC; c++)
                    exp_q.push_back(mk(4'h0, 1'b0, 1'b1, 2'(i), 1'b0, "G"));
            end
        end
    endtask

    // Edge (counting the start-sampling edge as 0) at which done should appear
    function automatic int done_edge();
        int s = 0;
        for (int i = 0; i < LEN; i++) begin
            if (rom_tab[i][7:6] == 2'd3) break;
            s += 2 + (int'(rom_tab[i][2:0]) + 1) * TICK + GAPC;
        end
        return s + 1;
    endfunction

    // Pulse start, optionally hold pause over edges [p_at, p_at+p_len), and follow the trace.
    // A paused cycle in NOTE/GAP repeats the previous cycle's outputs with the key released.
    task automatic play(input int p_at, input int p_len, output int n5, output int k_done);
        item_t it;
        item_t last;
        int    k;
        k      = 0;
        n5     = 0;
        k_done = -1;
        last   = mk(4'h0, 1'b0, 1'b0, 2'd0, 1'b0, "I");
        while (exp_q.size() > 0) begin
            start = (k == 0);
            pause = (k >= p_at) && (k < p_at + p_len);
            if (pause && (last.ph == "N" || last.ph == "G")) begin
                it = last;
                it.pressed = 1'b0;
                exp_q.push_front(it);
            end
            step();
            it = exp_q.pop_front();
            chk("kb_data", 32'(kb_data), 32'(it.data));
            chk("kb_pressed", 32'(kb_pressed), 32'(it.pressed));
            chk("busy", 32'(busy), 32'(it.busy));
            chk("done", 32'(done), 32'(it.done));
            if (it.busy) chk("note_idx", 32'(note_idx), 32'(it.idx));
            if (busy && kb_data == 4'd5) n5++;
            if (done && k_done < 0) k_done = k;
            last = it;
            k++;
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    initial begin
        int n5;
        int kd;
        int p_at;
        int p_len;
        logic [3:0] md;
        logic       mp;

        rom_tab = '{8'h48, 8'hA9, 8'h00, 8'hFF};

        // Reset: keypad activity must not leak through while reset is held
        man_pressed = 1'b1;
        man_data    = 4'h5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_kb_data", 32'(kb_data), 32'h0);
        chk("rst_kb_pressed", 32'(kb_pressed), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_note_idx", 32'(note_idx), 32'h0);
        @(negedge clk);
        sys_rst     = 1'b0;
        man_pressed = 1'b0;
        man_data    = 4'h0;

        // Idle passthrough with one-cycle latency, random keypad values
        for (int i = 0; i < 10; i++) begin
            md = 4'($urandom_range(0, 15));
            mp = 1'($urandom_range(0, 1));
            man_data    = md;
            man_pressed = mp;
            step();
            chk("pass_data", 32'(kb_data), 32'(md));
            chk("pass_pressed", 32'(kb_pressed), 32'(mp));
            chk("pass_busy", 32'(busy), 32'h0);
        end
        man_data    = 4'h0;
        man_pressed = 1'b0;
        step();

        // Plain playback to the end marker
        build(1, 1'b0);
        play(0, 0, n5, kd);
        chk("done_edge", 32'(kd), 32'(done_edge()));
        chk("note5_len", 32'(n5), 32'(2 * TICK));
        step();
        chk("done_one_cycle", 32'(done), 32'h0);

        // Five-cycle pause in the middle of note 5
        p_at = $urandom_range(11, 13);
        build(1, 1'b0);
        play(p_at, 5, n5, kd);
        chk("pause_note5_len", 32'(n5), 32'(2 * TICK + 5));
        chk("pause_done_edge", 32'(kd), 32'(done_edge() + 5));
        step();

        // Random pause anywhere in the song
        p_at  = $urandom_range(1, 28);
        p_len = $urandom_range(1, 4);
        build(1, 1'b0);
        play(p_at, p_len, n5, kd);
        step();

        // Looping: two full passes, no done, then stop
        loop_en = 1'b1;
        build(2, 1'b1);
        play(0, 0, n5, kd);
        chk("loop_no_done", 32'(kd), 32'hFFFF_FFFF);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_kb_data", 32'(kb_data), 32'h0);
        chk("stop_kb_pressed", 32'(kb_pressed), 32'h0);
        chk("stop_done", 32'(done), 32'h0);
        loop_en = 1'b0;
        step();

        // Manual override during the first note
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        chk("ovr_pre_data", 32'(kb_data), 32'h1);
        chk("ovr_pre_pressed", 32'(kb_pressed), 32'h1);
        man_pressed = 1'b1;
        man_data    = 4'h3;
        step();
        chk("ovr_busy", 32'(busy), 32'h0);
        chk("ovr_kb_data", 32'(kb_data), 32'h3);
        chk("ovr_kb_pressed", 32'(kb_pressed), 32'h1);
        chk("ovr_done", 32'(done), 32'h0);
        step();
        chk("ovr_done_later", 32'(done), 32'h0);
        man_pressed = 1'b0;
        man_data    = 4'h0;
        step();

        // start and stop together in idle
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", 32'(busy), 32'h0);
        step();
        chk("startstop_busy2", 32'(busy), 32'h0);

        // start while busy is ignored (during note 5, entry 1)
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (12) step();
        chk("busy_start_pre_idx", 32'(note_idx), 32'h1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_start_idx", 32'(note_idx), 32'h1);
        chk("busy_start_busy", 32'(busy), 32'h1);
        chk("busy_start_data", 32'(kb_data), 32'h5);
        step();
        chk("busy_start_idx2", 32'(note_idx), 32'h1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop2_busy", 32'(busy), 32'h0);
        step();

        // Asynchronous reset during the gap after entry 1, then replay from entry 0
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (18) step();
        chk("gap_busy", 32'(busy), 32'h1);
        chk("gap_idx", 32'(note_idx), 32'h1);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_idx", 32'(note_idx), 32'h0);
        chk("arst_kb_data", 32'(kb_data), 32'h0);
        chk("arst_kb_pressed", 32'(kb_pressed), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        @(negedge clk);
        sys_rst = 1'b0;
        build(1, 1'b0);
        play(0, 0, n5, kd);
        chk("replay_done_edge", 32'(kd), 32'(done_edge()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
